// File: rtl/uart_packet_rx.sv
// Framed packet receiver: SYNC/LEN/payload/CHK parse, buffer, verify, then stream payload out.
// Latency: out_valid rises the cycle after the CHK byte; drains one byte per cycle with out_ready high.
// Backpressure: out_ready low holds out_data/out_last; bytes arriving while draining are dropped and counted.
module uart_packet_rx #(
    parameter int          MAX_LEN        = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100_000,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axiiv,
    input  logic [7:0]           axiid,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     buffer [MAX_LEN];
    logic [IW-1:0]  len_m1;      // packet length minus one, so indices compare directly
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic [7:0]     sum;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           len_ok;
    logic           inc_pkt;
    logic           inc_err;
    logic           inc_drop;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign len_ok  = (axiid != 8'd0) && (axiid <= 8'(MAX_LEN));
    assign busy    = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and counter increment strobes; an arriving byte always beats the timeout
    always_comb begin
        state_nxt = state;
        inc_pkt   = 1'b0;
        inc_err   = 1'b0;
        inc_drop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (axiiv && axiid == SYNC_BYTE) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (axiiv) begin
                    if (len_ok) begin
                        state_nxt = S_PAYLOAD;
                    end else begin
                        state_nxt = S_IDLE;
                        inc_err   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    inc_err   = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (axiiv) begin
                    if (wr_idx == len_m1) state_nxt = S_CHECK;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    inc_err   = 1'b1;
                end
            end
            S_CHECK: begin
                if (axiiv) begin
                    if (axiid == sum) begin
                        state_nxt = S_DRAIN;
                        inc_pkt   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        inc_err   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    inc_err   = 1'b1;
                end
            end
            S_DRAIN: begin
                inc_drop = axiiv;
                if (out_ready && rd_idx == len_m1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload buffer; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && axiiv) buffer[wr_idx] <= axiid;
    end

    // Parse datapath, idle timer and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            len_m1    <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (axiiv || state_nxt == S_IDLE || state_nxt == S_DRAIN) tmo_cnt <= '0;
            else                                                      tmo_cnt <= tmo_cnt + 1'b1;

            if (state == S_LEN && axiiv && len_ok) begin
                len_m1 <= IW'(axiid - 8'd1);
                sum    <= axiid;
                wr_idx <= '0;
            end else if (state == S_PAYLOAD && axiiv) begin
                sum    <= sum + axiid;
                wr_idx <= wr_idx + 1'b1;
            end

            if (state == S_CHECK && state_nxt == S_DRAIN) begin
                out_valid <= 1'b1;
                out_data  <= buffer[0];
                out_last  <= (len_m1 == '0);
                rd_idx    <= '0;
            end else if (state == S_DRAIN && out_ready) begin
                if (rd_idx == len_m1) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    rd_idx   <= rd_idx + 1'b1;
                    out_data <= buffer[rd_idx + 1'b1];
                    out_last <= ((rd_idx + 1'b1) == len_m1);
                end
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (inc_pkt  && pkt_count  != '1) pkt_count  <= pkt_count  + 1'b1;
            if (inc_err  && err_count  != '1) err_count  <= err_count  + 1'b1;
            if (inc_drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Bench for uart_packet_rx: drives framed byte streams, scoreboards the drained payload.
// Latency: checks out_valid one cycle after CHK and one byte per cycle with out_ready high.
// Backpressure: toggles out_ready and checks held data while stalled and drops during drain.
module tb_uart_packet_rx;

    localparam int MAX_LEN = 32;
    localparam int TMO     = 20;
    localparam int CW      = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          axiiv = 1'b0;
    logic [7:0]    axiid = 8'h00;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] drop_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q [$];   // {last, data}
    logic [7:0] pay   [$];
    logic [7:0] raw   [$];

    logic       stalled = 1'b0;
    logic [7:0] st_data = 8'h00;
    logic       st_last = 1'b0;

    uart_packet_rx #(
        .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Output monitor: scoreboard pop on every transfer, stability while stalled
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== st_data || out_last !== st_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b",
                             out_valid, out_data, out_last, st_data, st_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_xfer: got d=%h l=%b, need no transfer", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        failures++;
                        $display("FAIL xfer_data: got l=%b d=%h, need l=%b d=%h",
                                 out_last, out_data, e[8], e[7:0]);
                    end
                end
            end
            stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
            st_data = out_data;
            st_last = out_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        axiiv = 1'b1;
        axiid = b;
        tick();
        axiiv = 1'b0;
    endtask

    task automatic send_raw();
        foreach (raw[i]) begin
            send_byte(raw[i]);
            tick();
        end
    endtask

    // Sends SYNC, LEN, pay[], CHK; returns just after the edge that samples CHK
    task automatic send_pkt(input logic [7:0] len, input bit push);
        logic [7:0] chk;
        chk = len;
        send_byte(8'hA5);
        tick();
        send_byte(len);
        tick();
        foreach (pay[i]) begin
            chk = chk + pay[i];
            if (push) exp_q.push_back({(i == pay.size() - 1), pay[i]});
            send_byte(pay[i]);
            tick();
        end
        axiiv = 1'b1;
        axiid = chk;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_before_chk: got %b, need 0", out_valid);
        end
        @(posedge clk);
        #1;
        axiiv = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy === 1'b1; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: got busy=%b, need 0 within %0d cycles", busy, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_valid, out_last, busy, out_data} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%h, need all 0",
                     out_valid, out_last, busy, out_data);
        end
        checks++;
        if ({pkt_count, err_count, drop_count} !== {3*CW{1'b0}}) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, need 0/0/0", pkt_count, err_count, drop_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_packet();
        out_ready = 1'b1;
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'd3, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL good_latency: got out_valid=%b, need 1", out_valid);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL good_rate: got busy=%b v=%b left=%0d, need 0 0 0", busy, out_valid, exp_q.size());
        end
        checks++;
        if (pkt_count !== 16'd1 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL good_counts: got pkt=%0d err=%0d, need 1 0", pkt_count, err_count);
        end
    endtask

    task automatic test_backpressure();
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b0;
        pay = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_done: got busy=%b v=%b left=%0d, need 0 0 0", busy, out_valid, exp_q.size());
        end
        checks++;
        if (pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_pkt: got %0d, need 2", pkt_count);
        end
    endtask

    task automatic test_bad_frames();
        out_ready = 1'b1;
        raw = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFF};
        send_raw();
        checks++;
        if (err_count !== 16'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_chk: got err=%0d busy=%b v=%b, need 1 0 0", err_count, busy, out_valid);
        end
        raw = '{8'hA5, 8'h00};
        send_raw();
        checks++;
        if (err_count !== 16'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len_zero: got err=%0d busy=%b, need 2 0", err_count, busy);
        end
        raw = '{8'hA5, 8'h21};
        send_raw();
        checks++;
        if (err_count !== 16'd3 || busy !== 1'b0 || pkt_count !== 16'd2) begin
            failures++;
            $display("FAIL len_big: got err=%0d busy=%b pkt=%0d, need 3 0 2", err_count, busy, pkt_count);
        end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        send_byte(8'hA5); tick();
        send_byte(8'h02); tick();
        send_byte(8'h10);
        repeat (TMO - 1) tick();
        checks++;
        if (busy !== 1'b1 || err_count !== 16'd3) begin
            failures++;
            $display("FAIL tmo_early: got busy=%b err=%0d, need 1 3", busy, err_count);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL tmo_fire: got busy=%b err=%0d, need 0 4", busy, err_count);
        end
        // byte landing exactly on the threshold cycle must keep the frame alive
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        send_byte(8'hA5); tick();
        send_byte(8'h02); tick();
        send_byte(8'h10);
        repeat (TMO - 1) tick();
        send_byte(8'h20);
        checks++;
        if (busy !== 1'b1 || err_count !== 16'd4) begin
            failures++;
            $display("FAIL tmo_race: got busy=%b err=%0d, need 1 4", busy, err_count);
        end
        tick();
        send_byte(8'h32);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL tmo_race_valid: got %b, need 1", out_valid);
        end
        wait_idle(20);
        checks++;
        if (pkt_count !== 16'd3 || err_count !== 16'd4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL tmo_race_pkt: got pkt=%0d err=%0d left=%0d, need 3 4 0",
                     pkt_count, err_count, exp_q.size());
        end
    endtask

    task automatic test_drain_drop();
        out_ready = 1'b0;
        pay.delete();
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'hFF);
        send_pkt(8'(MAX_LEN), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || out_last !== 1'b0) begin
            failures++;
            $display("FAIL wrap_first: got v=%b d=%h l=%b, need 1 ff 0", out_valid, out_data, out_last);
        end
        raw = '{8'hA5, 8'h12, 8'h34};
        send_raw();
        checks++;
        if (drop_count !== 16'd3 || pkt_count !== 16'd4 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_count: got drop=%0d pkt=%0d v=%b, need 3 4 1", drop_count, pkt_count, out_valid);
        end
        out_ready = 1'b1;
        wait_idle(2 * MAX_LEN);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_drained: got %0d left, need 0", exp_q.size());
        end
        raw = '{8'h00, 8'h7E};
        send_raw();
        checks++;
        if ({pkt_count, err_count, drop_count} !== {16'd4, 16'd4, 16'd3} || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_junk: got %0d/%0d/%0d busy=%b, need 4/4/3 0",
                     pkt_count, err_count, drop_count, busy);
        end
        pay = '{8'h5A};
        send_pkt(8'd1, 1'b1);
        wait_idle(10);
        checks++;
        if (pkt_count !== 16'd5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_junk: got pkt=%0d left=%0d, need 5 0", pkt_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        raw = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_raw();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || {pkt_count, err_count, drop_count} !== {3*CW{1'b0}}) begin
            failures++;
            $display("FAIL rst_payload: got v=%b busy=%b cnt=%0d/%0d/%0d, need 0 0 0/0/0",
                     out_valid, busy, pkt_count, err_count, drop_count);
        end
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        pay = '{8'h33, 8'h44};
        send_pkt(8'd2, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL pre_rst_drain: got v=%b pkt=%0d, need 1 1", out_valid, pkt_count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_last, busy, out_data} !== 11'd0 ||
            {pkt_count, err_count, drop_count} !== {3*CW{1'b0}}) begin
            failures++;
            $display("FAIL rst_drain: got v=%b l=%b busy=%b d=%h cnt=%0d/%0d/%0d, need all 0",
                     out_valid, out_last, busy, out_data, pkt_count, err_count, drop_count);
        end
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        pay = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'd3, 1'b1);
        wait_idle(10);
        checks++;
        if (pkt_count !== 16'd1 || err_count !== 16'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_rst_pkt: got pkt=%0d err=%0d left=%0d, need 1 0 0",
                     pkt_count, err_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_backpressure();
        test_bad_frames();
        test_timeout();
        test_drain_drop();
        test_reset_mid();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
